// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory burst sequencer.
//   state_t    : sequencer states
//   DIR_*      : encoding of the dir command input
//   MEM_WORDS  : size of the main memory in words, used for the range check
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    RD_DRAIN = 3'd2,
    WR       = 3'd3,
    FIN      = 3'd4
  } state_t;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  localparam int MEM_WORDS = 1024;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO used on the read path.
//   clk, reset          : clock, asynchronous active-low reset
//   push, push_data     : write side; a push while full is dropped unless a pop
//                         happens on the same edge
//   pop, head           : read side; head reads as 0 while empty
//   full, empty, count  : occupancy status
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer between the matrix-multiplier datapath and the single-port
// main memory. A start strobe launches either a read burst (memory -> rd_*
// stream) or a write burst (wr_* stream -> memory) over consecutive addresses.
//   clk, reset                      : clock, asynchronous active-low reset
//   start, dir, base_addr, length   : command, sampled only in IDLE
//   busy, done, err                 : status; err qualifies the done pulse
//   mem_write_readBar, mem_address,
//   mem_data_in, mem_data_out       : memory port (read data one cycle late)
//   rd_data, rd_valid, rd_ready     : read stream out of the FIFO
//   wr_data, wr_valid, wr_ready     : write stream into memory
//
// state    | meaning
// IDLE     | waiting for start
// RD       | issuing reads while FIFO space allows
// RD_DRAIN | all reads issued, waiting for last data and empty FIFO
// WR       | writing each accepted stream word
// FIN      | one-cycle done pulse, err valid
module mem_burst_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_write_readBar,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic              err_q, err_d;

  logic              issue;
  logic              bad_cmd;
  logic [ADDR_W+1:0] end_addr;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;

  assign end_addr = {2'b00, base_addr} + {1'b0, length};
  assign bad_cmd  = (length == '0) || (end_addr > (ADDR_W+2)'(MEM_WORDS));

  // Occupancy plus the read still in flight must leave room, so the word
  // returning next cycle always has a slot even with rd_ready low.
  assign issue = (state_q == RD) && (rem_q != '0) && !fifo_full &&
                 ((32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH);

  assign rd_valid = !fifo_empty;
  assign rd_data  = fifo_head;
  assign fifo_pop = rd_valid && rd_ready;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (mem_data_out),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    rem_d             = rem_q;
    err_d             = err_q;
    inflight_d        = issue;
    mem_write_readBar = 1'b0;
    mem_address       = '0;
    mem_data_in       = '0;
    wr_ready          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (bad_cmd) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            err_d   = 1'b0;
            addr_d  = base_addr;
            rem_d   = length;
            state_d = (dir == DIR_WRITE) ? WR : RD;
          end
        end
      end

      RD: begin
        if (issue) begin
          mem_address = addr_q;
          addr_d      = addr_q + 1'b1;
          rem_d       = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) state_d = RD_DRAIN;
        end
      end

      RD_DRAIN: begin
        if (!inflight_q && fifo_empty) state_d = FIN;
      end

      WR: begin
        wr_ready          = 1'b1;
        mem_address       = addr_q;
        mem_data_in       = wr_data;
        mem_write_readBar = wr_valid;
        if (wr_valid) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) state_d = FIN;
        end
      end

      FIN: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);
  assign err  = (state_q == FIN) && err_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
module tb_mem_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] length = '0;
  logic        busy, done, err;
  logic        mem_write_readBar;
  logic [9:0]  mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_burst_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .dir               (dir),
    .base_addr         (base_addr),
    .length            (length),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .mem_write_readBar (mem_write_readBar),
    .mem_address       (mem_address),
    .mem_data_in       (mem_data_in),
    .mem_data_out      (mem_data_out),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .wr_data           (wr_data),
    .wr_valid          (wr_valid),
    .wr_ready          (wr_ready)
  );

  // Memory environment: single port, registered read data.
  logic [31:0] mem [1024];
  logic [31:0] mem_rdata = '0;
  int          wr_count = 0;
  int          we_bad = 0;
  bit          in_write = 1'b0;

  always @(posedge clk) begin
    if (mem_write_readBar) begin
      mem[mem_address] <= mem_data_in;
      wr_count <= wr_count + 1;
    end
    if (mem_write_readBar && !in_write) we_bad <= we_bad + 1;
    mem_rdata <= mem[mem_address];
  end
  assign mem_data_out = mem_rdata;

  // Reference model of memory contents, updated from accepted stream words.
  logic [31:0] ref_mem [1024];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: rd_ready always 1; 1: pattern 1,0,0,...; 2: random.
  // poke: pulse start with other arguments mid-burst.
  task automatic run_read(input int base, input int len, input int mode, input bit poke);
    logic [31:0] exp_q[$];
    int cyc = 0, first_v = -1, last_hs = -1, prev_hs = -1, done_at = -1;
    int gaps = 0, max_occ = 0, extra = 0;
    for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[base + i]);
    @(negedge clk);
    start = 1'b1; dir = 1'b0; base_addr = 10'(base); length = 11'(len);
    while (done_at < 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke && cyc == 4) begin
        start = 1'b1; dir = 1'b1; base_addr = 10'd500; length = 11'd2;
      end
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ((cyc - 1) % 3 == 0);
        default: rd_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (32'(dut.u_fifo.count) > max_occ) max_occ = 32'(dut.u_fifo.count);
      if (rd_valid && first_v < 0) first_v = cyc;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) extra++;
        else chk("rd_data", rd_data, exp_q.pop_front());
        if (prev_hs >= 0 && cyc != prev_hs + 1) gaps++;
        prev_hs = cyc;
        last_hs = cyc;
      end
      if (done) begin
        done_at = cyc;
        chk("rd_err", err, 0);
      end
    end
    rd_ready = 1'b0;
    chk("rd_done_seen", done_at >= 0, 1);
    chk("rd_words_left", exp_q.size(), 0);
    chk("rd_extra_words", extra, 0);
    chk("rd_done_lag", (done_at - last_hs >= 1) && (done_at - last_hs <= 2), 1);
    chk("fifo_occ_le_depth", max_occ <= 4, 1);
    if (mode == 0) begin
      chk("rd_first_latency", first_v, 3);
      chk("rd_gaps", gaps, 0);
    end
    @(negedge clk);
    chk("rd_done_single", done, 0);
    chk("rd_busy_after", busy, 0);
    chk("rd_no_write", we_bad, 0);
  endtask

  // mode 0: data 0xA0+i with a one-cycle gap after the second word; 1: random.
  // rst_after > 0: assert reset once that many words were accepted.
  task automatic run_write(input int base, input int len, input int mode, input int rst_after);
    int cyc = 0, idx = 0, done_at = -1, wc0, wc1, done_in_rst = 0;
    bit gap_done = 1'b0, aborted = 1'b0, v;
    logic [31:0] d;
    wc0 = wr_count;
    in_write = 1'b1;
    @(negedge clk);
    start = 1'b1; dir = 1'b1; base_addr = 10'(base); length = 11'(len);
    while (done_at < 0 && !aborted && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) begin
        done_at = cyc;
        chk("wr_err", err, 0);
        chk("wr_all_accepted", idx, len);
      end
      if (rst_after > 0 && idx == rst_after) begin
        reset = 1'b0;
        wr_valid = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        #1;
        chk("rst_outputs", {busy, done, err, mem_write_readBar, wr_ready, rd_valid},
            0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_data_in", mem_data_in, 0);
        chk("rst_rd_data", rd_data, 0);
        wc1 = wr_count;
        repeat (3) begin
          @(negedge clk);
          if (done) done_in_rst++;
        end
        chk("rst_no_writes", wr_count, wc1);
        chk("rst_no_done", done_in_rst, 0);
        wr_valid = 1'b0;
        reset = 1'b1;
        aborted = 1'b1;
      end else begin
        v = 1'b0;
        d = '0;
        if (idx < len) begin
          d = (mode == 0) ? 32'hA0 + 32'(idx) : $urandom;
          if (mode == 0) begin
            v = 1'b1;
            if (idx == 2 && !gap_done && wr_ready) begin
              v = 1'b0;
              gap_done = 1'b1;
            end
          end else begin
            v = ($urandom_range(0, 3) != 0);
          end
        end
        wr_valid = v;
        wr_data = d;
        if (v && wr_ready) begin
          ref_mem[base + idx] = d;
          idx++;
        end
      end
    end
    wr_valid = 1'b0;
    in_write = 1'b0;
    if (!aborted) begin
      chk("wr_done_seen", done_at >= 0, 1);
      chk("wr_count", wr_count - wc0, len);
      for (int i = 0; i < len; i++) chk("wr_mem", mem[base + i], ref_mem[base + i]);
      @(negedge clk);
      chk("wr_done_single", done, 0);
      chk("wr_busy_after", busy, 0);
    end
  endtask

  task automatic run_reject(input int base, input int len);
    int cyc = 0, done_at = -1, wc0;
    wc0 = wr_count;
    @(negedge clk);
    start = 1'b1; dir = 1'b1; base_addr = 10'(base); length = 11'(len);
    while (done_at < 0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) begin
        done_at = cyc;
        chk("rej_err", err, 1);
      end
    end
    chk("rej_done_seen", done_at >= 0, 1);
    chk("rej_done_time", (done_at >= 1) && (done_at <= 2), 1);
    @(negedge clk);
    chk("rej_busy_after", busy, 0);
    chk("rej_no_write", wr_count, wc0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, l;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h100 + 32'(i);
      ref_mem[i] = 32'h100 + 32'(i);
    end
    repeat (3) @(negedge clk);
    chk("reset_status", {busy, done, err, mem_write_readBar, rd_valid, wr_ready}, 0);
    chk("reset_mem_address", mem_address, 0);
    chk("reset_mem_data_in", mem_data_in, 0);
    chk("reset_rd_data", rd_data, 0);
    reset = 1'b1;
    @(negedge clk);

    run_read(3, 5, 0, 1'b0);
    run_read(0, 8, 1, 1'b0);
    run_write(1020, 4, 0, 0);
    run_read(1020, 4, 0, 1'b0);
    run_reject(1022, 3);
    run_reject(5, 0);
    run_read(40, 12, 0, 1'b1);
    run_write(200, 8, 0, 3);
    run_read(200, 8, 0, 1'b0);
    run_write(300, 6, 1, 0);
    run_read(300, 6, 2, 1'b0);

    for (int k = 0; k < 8; k++) begin
      b = $urandom_range(0, 1000);
      l = $urandom_range(1, 24);
      if (b + l > 1024) l = 1024 - b;
      if ($urandom_range(0, 1) == 1) run_write(b, l, 1, 0);
      run_read(b, l, 2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
